// File: rtl/segscan_driver_if.sv
// Host/display bundle for segscan_driver: buffered digit data with load/ack handshake in,
// scanned anode/segment/dot drive and frame strobe out.
interface segscan_driver_if #(
  parameter int NUM_DIGITS   = 4,
  parameter int BRIGHT_WIDTH = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dots;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    load;
  logic [BRIGHT_WIDTH-1:0] brightness;
  logic                    ld_ack;
  logic                    frame;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output digits, dots, blank, load, brightness,
    input  ld_ack, frame, an, seg, dp
  );

  modport slave (
    input  digits, dots, blank, load, brightness,
    output ld_ack, frame, an, seg, dp
  );
endinterface

// File: rtl/segscan_driver.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness and double-buffered loads.
// Optional leading-zero blanking is enabled by defining SEGSCAN_LZB_EN.
module segscan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_WIDTH    = 18,
  parameter int BRIGHT_WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  segscan_driver_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam logic [SEL_W-1:0]     SEL_LEFT = SEL_W'(NUM_DIGITS - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_MAX  = '1;

  logic [DIV_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [4*NUM_DIGITS-1:0] stg_digits_q, stg_digits_d, act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   stg_dots_q, stg_dots_d, act_dots_q, act_dots_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
  logic                    pending_q, pending_d;
  logic                    xfer_q, xfer_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;
  logic                    ld_ack_q, ld_ack_d;

  logic                    boundary;
  logic                    digit_on;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   dark_mask;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'b0000001;
      4'h1: hex_to_seg = 7'b1001111;
      4'h2: hex_to_seg = 7'b0010010;
      4'h3: hex_to_seg = 7'b0000110;
      4'h4: hex_to_seg = 7'b1001100;
      4'h5: hex_to_seg = 7'b0100100;
      4'h6: hex_to_seg = 7'b0100000;
      4'h7: hex_to_seg = 7'b0001111;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0000100;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b1100000;
      4'hC: hex_to_seg = 7'b0110001;
      4'hD: hex_to_seg = 7'b1000010;
      4'hE: hex_to_seg = 7'b0110000;
      default: hex_to_seg = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    boundary = (cnt_q == CNT_MAX) && (sel_q == '0);

    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CNT_MAX) begin
      sel_d = (sel_q == '0) ? SEL_LEFT : sel_q - 1'b1;
    end

    // A load on the boundary cycle lands in staging after the old staging has moved to active.
    stg_digits_d = stg_digits_q;
    stg_dots_d   = stg_dots_q;
    stg_blank_d  = stg_blank_q;
    act_digits_d = act_digits_q;
    act_dots_d   = act_dots_q;
    act_blank_d  = act_blank_q;
    pending_d    = pending_q;
    if (boundary && pending_q) begin
      act_digits_d = stg_digits_q;
      act_dots_d   = stg_dots_q;
      act_blank_d  = stg_blank_q;
      pending_d    = 1'b0;
    end
    if (bus.load) begin
      stg_digits_d = bus.digits;
      stg_dots_d   = bus.dots;
      stg_blank_d  = bus.blank;
      pending_d    = 1'b1;
    end
    xfer_d = boundary && pending_q;

    dark_mask = act_blank_q;
`ifdef SEGSCAN_LZB_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        lead = lead && (act_digits_q[4*i +: 4] == 4'h0) && !act_dots_q[i];
        if (lead) dark_mask[i] = 1'b1;
      end
    end
`endif

    nibble   = act_digits_q[{sel_q, 2'b00} +: 4];
    digit_on = (cnt_q[DIV_WIDTH-1 -: BRIGHT_WIDTH] < bus.brightness) && !dark_mask[sel_q];

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (digit_on) begin
      an_d  = ~(NUM_DIGITS'(1) << sel_q);
      seg_d = hex_to_seg(nibble);
      dp_d  = ~act_dots_q[sel_q];
    end
    frame_d  = (cnt_q == '0) && (sel_q == SEL_LEFT);
    ld_ack_d = xfer_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sel_q        <= SEL_LEFT;
      stg_digits_q <= '0;
      stg_dots_q   <= '0;
      stg_blank_q  <= '1;
      act_digits_q <= '0;
      act_dots_q   <= '0;
      act_blank_q  <= '1;
      pending_q    <= 1'b0;
      xfer_q       <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
      ld_ack_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      stg_digits_q <= stg_digits_d;
      stg_dots_q   <= stg_dots_d;
      stg_blank_q  <= stg_blank_d;
      act_digits_q <= act_digits_d;
      act_dots_q   <= act_dots_d;
      act_blank_q  <= act_blank_d;
      pending_q    <= pending_d;
      xfer_q       <= xfer_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_q      <= frame_d;
      ld_ack_q     <= ld_ack_d;
    end
  end

  assign bus.an     = an_q;
  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;
  assign bus.frame  = frame_q;
  assign bus.ld_ack = ld_ack_q;
endmodule

// File: tb/tb_segscan_driver.sv
// Scoreboard bench for segscan_driver (4 digits, 16-cycle dwell): stimulus queues one expected
// frame image per frame, a monitor checks every cycle of each frame as the frame strobe arrives.
module tb_segscan_driver;
  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BW = 4;

  localparam logic [6:0] S0  = 7'b0000001;
  localparam logic [6:0] S1  = 7'b1001111;
  localparam logic [6:0] S2  = 7'b0010010;
  localparam logic [6:0] S3  = 7'b0000110;
  localparam logic [6:0] S5  = 7'b0100100;
  localparam logic [6:0] SA  = 7'b0001000;
  localparam logic [6:0] SF  = 7'b0111000;
  localparam logic [6:0] OFF = 7'h7F;

  typedef struct packed {
    logic            stop;
    logic            ack;
    logic [3:0]      bright;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } frame_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  segscan_driver_if #(.NUM_DIGITS(ND), .BRIGHT_WIDTH(BW)) bus ();

  segscan_driver #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .BRIGHT_WIDTH(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  frame_exp_t exp_q[$];
  int checks_total  = 0;
  int checks_passed = 0;
  bit mon_done      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic frame_exp_t mk(input logic ack, input logic [3:0] bright, input logic [3:0] lit,
                                    input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                                    input logic [6:0] s0, input logic [3:0] dpn);
    frame_exp_t r;
    r.stop   = 1'b0;
    r.ack    = ack;
    r.bright = bright;
    r.lit    = lit;
    r.seg[3] = s3;
    r.seg[2] = s2;
    r.seg[1] = s1;
    r.seg[0] = s0;
    r.dpn    = dpn;
    return r;
  endfunction

  function automatic frame_exp_t dark();
    return mk(1'b0, 4'd15, 4'b0000, OFF, OFF, OFF, OFF, 4'hF);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.frame === 1'b1) return;
    end
    checkOutput("frame_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dots, input logic [3:0] blank);
    bus.digits = d;
    bus.dots   = dots;
    bus.blank  = blank;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  // Stimulus: at each frame start, queue the image expected for the following frame.
  initial begin
    frame_exp_t stop_rec;
    int acks, lit_cycles, frames;
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.digits     = '0;
    bus.dots       = '0;
    bus.blank      = '0;
    bus.brightness = 4'd15;
    wait_cycles(4);
    exp_q.push_back(dark());
    rst = 1'b0;

    wait_frame();
    exp_q.push_back(dark());
    wait_frame();
    exp_q.push_back(dark());

    wait_frame();
    exp_q.push_back(mk(1'b1, 4'd15, 4'b1111, S1, S2, SA, SF, 4'b1101));
    wait_cycles(10);
    applyStimulus(16'h12AF, 4'b0010, 4'b0000);

    wait_frame();
    exp_q.push_back(mk(1'b0, 4'd15, 4'b1111, S1, S2, SA, SF, 4'b1101));

    wait_frame();
    exp_q.push_back(mk(1'b1, 4'd15, 4'b1111, S2, S2, S2, S2, 4'hF));
    wait_cycles(5);
    applyStimulus(16'h1111, 4'b0000, 4'b0000);
    wait_cycles(14);
    applyStimulus(16'h2222, 4'b0000, 4'b0000);
    wait_cycles(41);
    applyStimulus(16'h3333, 4'b0000, 4'b0000);

    wait_frame();
    exp_q.push_back(mk(1'b1, 4'd15, 4'b1111, S3, S3, S3, S3, 4'hF));

    wait_frame();
    exp_q.push_back(mk(1'b0, 4'd4, 4'b1111, S3, S3, S3, S3, 4'hF));
    wait_cycles(63);
    bus.brightness = 4'd4;

    wait_frame();
    exp_q.push_back(mk(1'b0, 4'd0, 4'b1111, S3, S3, S3, S3, 4'hF));
    wait_cycles(63);
    bus.brightness = 4'd0;

    wait_frame();
`ifdef SEGSCAN_LZB_EN
    exp_q.push_back(mk(1'b1, 4'd15, 4'b0011, S0, S0, S5, S0, 4'hF));
`else
    exp_q.push_back(mk(1'b1, 4'd15, 4'b1111, S0, S0, S5, S0, 4'hF));
`endif
    wait_cycles(10);
    applyStimulus(16'h0050, 4'b0000, 4'b0000);
    wait_cycles(52);
    bus.brightness = 4'd15;

    wait_frame();
`ifdef SEGSCAN_LZB_EN
    exp_q.push_back(mk(1'b1, 4'd15, 4'b0001, S0, S0, S0, S0, 4'hF));
`else
    exp_q.push_back(mk(1'b1, 4'd15, 4'b1111, S0, S0, S0, S0, 4'hF));
`endif
    wait_cycles(10);
    applyStimulus(16'h0000, 4'b0000, 4'b0000);

    wait_frame();
`ifdef SEGSCAN_LZB_EN
    exp_q.push_back(mk(1'b1, 4'd15, 4'b0110, S0, S0, S0, S0, 4'b1011));
`else
    exp_q.push_back(mk(1'b1, 4'd15, 4'b1110, S0, S0, S0, S0, 4'b1011));
`endif
    wait_cycles(10);
    applyStimulus(16'h0000, 4'b0100, 4'b0001);

    wait_frame();
    stop_rec      = dark();
    stop_rec.stop = 1'b1;
    exp_q.push_back(stop_rec);

    for (int i = 0; i < 300 && !mon_done; i++) @(negedge clk);
    if (!mon_done) checkOutput("monitor_done_timeout", 32'd0, 32'd1);

    // Reset mid-dwell with a load still pending must discard it.
    @(negedge clk);
    applyStimulus(16'h8888, 4'b1111, 4'b0000);
    wait_cycles(4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_an", 32'(bus.an), 32'hF);
    checkOutput("rst_seg", 32'(bus.seg), 32'h7F);
    checkOutput("rst_dp", 32'(bus.dp), 32'd1);
    checkOutput("rst_frame", 32'(bus.frame), 32'd0);
    checkOutput("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_frame", 32'(bus.frame), 32'd1);
    acks       = 0;
    lit_cycles = 0;
    frames     = 0;
    for (int c = 0; c < 130; c++) begin
      if (bus.ld_ack === 1'b1) acks++;
      if (bus.an !== 4'hF) lit_cycles++;
      if (c > 0 && bus.frame === 1'b1) frames++;
      @(negedge clk);
    end
    checkOutput("release_ld_ack_count", 32'(acks), 32'd0);
    checkOutput("release_lit_cycles", 32'(lit_cycles), 32'd0);
    checkOutput("release_frame_count", 32'(frames), 32'd2);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Monitor: each frame strobe pops one expected image and checks all 64 cycles of it.
  initial begin
    frame_exp_t rec;
    int nframes, bad, extra, d, ph;
    logic on, ack0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    string first_bad;
    nframes = 0;
    begin : find_first
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (rst === 1'b0 && bus.frame === 1'b1) disable find_first;
      end
      checkOutput("first_frame_timeout", 32'd0, 32'd1);
    end
    while (nframes < 40) begin
      if (exp_q.size() == 0) begin
        checkOutput("exp_queue_empty", 32'd0, 32'd1);
        break;
      end
      rec = exp_q.pop_front();
      if (rec.stop) break;
      if (nframes > 0) checkOutput($sformatf("frame%0d_start", nframes), 32'(bus.frame), 32'd1);
      bad       = 0;
      extra     = 0;
      ack0      = 1'b0;
      first_bad = "";
      for (int c = 0; c < 64; c++) begin
        if (c > 0) @(negedge clk);
        d     = 3 - c / 16;
        ph    = c % 16;
        on    = rec.lit[d] && (ph < int'(rec.bright));
        e_an  = on ? ~(4'b0001 << d) : 4'hF;
        e_seg = on ? rec.seg[d] : OFF;
        e_dp  = on ? rec.dpn[d] : 1'b1;
        if (c == 0) ack0 = bus.ld_ack;
        else if (bus.frame !== 1'b0 || bus.ld_ack !== 1'b0) extra++;
        if (bus.an !== e_an || bus.seg !== e_seg || bus.dp !== e_dp) begin
          if (bad == 0)
            first_bad = $sformatf("c%0d an=%b/%b seg=%b/%b dp=%b/%b",
                                  c, bus.an, e_an, bus.seg, e_seg, bus.dp, e_dp);
          bad++;
        end
      end
      checkOutput($sformatf("frame%0d_ld_ack", nframes), 32'(ack0), 32'(rec.ack));
      checkOutput($sformatf("frame%0d_stray_strobes", nframes), 32'(extra), 32'd0);
      checkOutput($sformatf("frame%0d_scan_bad_cycles %s", nframes, first_bad), 32'(bad), 32'd0);
      nframes++;
      @(negedge clk);
    end
    mon_done = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
